// File: rtl/sr_sched_pkg.sv
// rtl/sr_sched_pkg.sv - shared types and command encodings for the SR bank scheduler
package sr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLR   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic CMD_SET = 1'b1;
  localparam logic CMD_RST = 1'b0;

endpackage

// File: rtl/sr_rr_arbiter.sv
// rtl/sr_rr_arbiter.sv - combinational round-robin pick starting at a parent-owned pointer
module sr_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx,
  output logic            win_vld
);

  always_comb begin
    int k;
    k       = 0;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (en && !win_vld && req[k]) begin
        win_vld   = 1'b1;
        win_oh[k] = 1'b1;
        win_idx   = PW'(k);
      end
    end
  end

endmodule

// File: rtl/sr_bank_cmd_scheduler.sv
// rtl/sr_bank_cmd_scheduler.sv - arbitrates set/reset requests onto one SR flip-flop bank with readback check
module sr_bank_cmd_scheduler
  import sr_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = $clog2(NBITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_set,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic                 clr_all,
  input  logic                 err_clr,
  input  logic [NBITS-1:0]     q_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     s_out,
  output logic [NBITS-1:0]     r_out,
  output logic                 busy,
  output logic                 err,
  output logic [IDXW-1:0]      err_idx
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = 2 ** IDXW;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_q;
  logic            set_q;
  logic [IDXW-1:0] idx_q;
  logic            clr_pend;
  logic            was_clr;

  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic            clr_go;

  assign clr_go = clr_pend | clr_all;

  sr_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .en      (state == IDLE && !clr_go),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Decoding through a power-of-two wide vector makes out-of-range indices produce no pulse.
  logic [DW-1:0]    dec_full;
  logic [NBITS-1:0] idx_hit;
  logic             idx_ok;
  logic             q_bit;

  assign dec_full = {{(DW-1){1'b0}}, 1'b1} << idx_q;
  assign idx_hit  = dec_full[NBITS-1:0];
  assign idx_ok   = |idx_hit;
  assign q_bit    = |(q_in & idx_hit);

  logic            mismatch;
  logic [IDXW-1:0] fail_idx;

  always_comb begin
    mismatch = 1'b0;
    fail_idx = idx_q;
    if (was_clr) begin
      mismatch = |q_in;
      for (int i = NBITS - 1; i >= 0; i--) begin
        if (q_in[i]) fail_idx = IDXW'(i);
      end
    end else begin
      mismatch = !idx_ok || (q_bit != set_q);
    end
  end

  always_comb begin
    gnt   = '0;
    s_out = '0;
    r_out = '0;
    case (state)
      ISSUE: begin
        gnt[win_q] = 1'b1;
        if (set_q == CMD_SET) s_out = idx_hit;
        else                  r_out = idx_hit;
      end
      CLR:     r_out = '1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      win_q   <= '0;
      set_q   <= CMD_RST;
      idx_q   <= '0;
      was_clr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_go) begin
            state   <= CLR;
            was_clr <= 1'b1;
          end else if (win_vld) begin
            state   <= ISSUE;
            was_clr <= 1'b0;
            win_q   <= win_idx;
            set_q   <= req_set[win_idx];
            idx_q   <= req_idx[int'(win_idx)*IDXW +: IDXW];
            ptr     <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        ISSUE, CLR: state <= CHECK;
        default:    state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_pend <= 1'b0;
    else        clr_pend <= clr_all | (clr_pend & (state != CLR));
  end

  // A fresh mismatch beats a simultaneous err_clr so the failure is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_idx <= '0;
    end else if (state == CHECK && mismatch && (!err || err_clr)) begin
      err     <= 1'b1;
      err_idx <= fail_idx;
    end else if (err_clr) begin
      err     <= 1'b0;
      err_idx <= '0;
    end
  end

endmodule

// File: tb/tb_sr_bank_cmd_scheduler.sv
// tb/tb_sr_bank_cmd_scheduler.sv - scoreboard bench for sr_bank_cmd_scheduler with an SR bank model
module tb_sr_bank_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_set;
  logic [11:0] req_idx;
  logic        clr_all;
  logic        err_clr;
  logic [7:0]  q_in;
  logic [3:0]  gnt;
  logic [7:0]  s_out;
  logic [7:0]  r_out;
  logic        busy;
  logic        err;
  logic [2:0]  err_idx;

  logic [7:0] bank = 8'h00;
  logic [7:0] stuck0 = 8'h00;
  logic [7:0] stuck1 = 8'h00;
  logic [7:0] load_val = 8'h00;
  logic       load_en = 1'b0;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] s;
    logic [7:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  sr_bank_cmd_scheduler #(.NREQ(4), .NBITS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_set (req_set),
    .req_idx (req_idx),
    .clr_all (clr_all),
    .err_clr (err_clr),
    .q_in    (q_in),
    .gnt     (gnt),
    .s_out   (s_out),
    .r_out   (r_out),
    .busy    (busy),
    .err     (err),
    .err_idx (err_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) bank <= load_val;
    else         bank <= s_out | (bank & ~r_out);
  end

  assign q_in = (bank & ~stuck0) | stuck1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (gnt != 4'h0 || s_out != 8'h00 || r_out != 8'h00)) begin
      n_cmp++;
      if ((s_out & r_out) != 8'h00 || !$onehot0(gnt)) begin
        n_bad++;
        $display("FAIL invariant: gnt=%b s=%h r=%h", gnt, s_out, r_out);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got gnt=%b s=%h r=%h, want none", gnt, s_out, r_out);
      end else begin
        e = exp_q.pop_front();
        if ({gnt, s_out, r_out} !== e) begin
          n_bad++;
          $display("FAIL pulse: got gnt=%b s=%h r=%h, want gnt=%b s=%h r=%h",
                   gnt, s_out, r_out, e.g, e.s, e.r);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Requesters drop their line once their grant is seen.
  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~gnt;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] s, input logic [7:0] r);
    exp_t e;
    e.g = g;
    e.s = s;
    e.r = r;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'h0; req_set = 4'h0; req_idx = 12'h000;
    clr_all = 1'b0; err_clr = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_s", 32'(s_out), 32'h0);
    chk("rst_r", 32'(r_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_idx", 32'(err_idx), 32'h0);
    tick();
    rst_n = 1'b1;
    run(5);
    chk("idle_busy", 32'(busy), 32'h0);

    // single set of bit 3
    req_set = 4'b0001; req_idx = {3'd6, 3'd4, 3'd2, 3'd3}; req = 4'b0001;
    push(4'b0001, 8'h08, 8'h00);
    tick();
    chk("t2_busy_issue", 32'(busy), 32'h1);
    run(2);
    chk("t2_busy_done", 32'(busy), 32'h0);
    chk("t2_err", 32'(err), 32'h0);
    chk("t2_q3", 32'(q_in[3]), 32'h1);

    rst_n = 1'b0; #1; rst_n = 1'b1;

    // all four requesters, pointer starting at 0
    req_set = 4'b0101; req_idx = {3'd6, 3'd4, 3'd2, 3'd1}; req = 4'b1111;
    push(4'b0001, 8'h02, 8'h00);
    push(4'b0010, 8'h00, 8'h04);
    push(4'b0100, 8'h10, 8'h00);
    push(4'b1000, 8'h00, 8'h40);
    run(12);
    chk("t3_err", 32'(err), 32'h0);
    req = 4'b0101;
    push(4'b0001, 8'h02, 8'h00);
    push(4'b0100, 8'h10, 8'h00);
    run(6);
    chk("t3_req_left", 32'(req), 32'h0);

    // clr_all beats a pending request
    load_val = 8'hFF; load_en = 1'b1; tick(); load_en = 1'b0;
    req_set = 4'b0000; req = 4'b0010; clr_all = 1'b1;
    push(4'b0000, 8'h00, 8'hFF);
    push(4'b0010, 8'h00, 8'h04);
    tick();
    clr_all = 1'b0;
    run(5);
    chk("t4_err", 32'(err), 32'h0);
    chk("t4_bank", 32'(q_in), 32'h0);

    // stuck-at-0 on bit 5
    stuck0 = 8'h20; req_set = 4'b0100; req_idx = {3'd6, 3'd5, 3'd2, 3'd1}; req = 4'b0100;
    push(4'b0100, 8'h20, 8'h00);
    run(3);
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_err_idx", 32'(err_idx), 32'h5);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_err_clr", 32'(err), 32'h0);
    chk("t5_err_idx_clr", 32'(err_idx), 32'h0);
    stuck0 = 8'h00;

    // clr readback failure reports the lowest failing bit
    stuck1 = 8'h48; clr_all = 1'b1;
    push(4'b0000, 8'h00, 8'hFF);
    tick();
    clr_all = 1'b0;
    run(2);
    chk("t5c_err", 32'(err), 32'h1);
    chk("t5c_err_idx", 32'(err_idx), 32'h3);

    // err_clr coincident with a new mismatch: mismatch wins
    stuck1 = 8'h40; clr_all = 1'b1;
    push(4'b0000, 8'h00, 8'hFF);
    tick();
    clr_all = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5d_err", 32'(err), 32'h1);
    chk("t5d_err_idx", 32'(err_idx), 32'h6);
    stuck1 = 8'h00;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5d_err_clr", 32'(err), 32'h0);

    // reset while a pulse is on the bank
    req_set = 4'b1001; req_idx = {3'd7, 3'd5, 3'd2, 3'd0}; req = 4'b0001;
    tick();
    chk("t6_pre_gnt", 32'(gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_s", 32'(s_out), 32'h0);
    chk("t6_r", 32'(r_out), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    req = 4'b0000;
    #2;
    rst_n = 1'b1;
    run(5);
    req = 4'b1001;
    push(4'b0001, 8'h01, 8'h00);
    push(4'b1000, 8'h80, 8'h00);
    run(6);
    chk("t6_err", 32'(err), 32'h0);

    run(2);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
